// File: rtl/picorv32_pcpi_pkg.sv
// picorv32_pcpi_pkg: shared PCPI hub states, widths and MUL/DIV decode constants
package picorv32_pcpi_pkg;
    localparam int PCPI_W = 32;
    localparam logic [6:0] MULDIV_OPCODE = 7'b0110011;
    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    typedef enum logic [2:0] {IDLE, PEND, BUSY, DONE, TRAP} hub_state_t;

    function automatic logic is_muldiv(input logic [PCPI_W-1:0] insn);
        return insn[6:0] == MULDIV_OPCODE && insn[31:25] == MULDIV_FUNCT7;
    endfunction
endpackage

// File: rtl/picorv32_pcpi_resp_sel.sv
// picorv32_pcpi_resp_sel: lowest-index ready slot wins the wr/rd mux; flags multi-hot ready
module picorv32_pcpi_resp_sel
    import picorv32_pcpi_pkg::*;
#(
    parameter int NUM_CP = 2
) (
    input  logic [NUM_CP-1:0]        cp_ready,
    input  logic [NUM_CP-1:0]        cp_wr,
    input  logic [PCPI_W*NUM_CP-1:0] cp_rd,
    output logic                     any,
    output logic                     multi,
    output logic                     wr,
    output logic [PCPI_W-1:0]        rd
);
    always_comb begin
        wr = 1'b0;
        rd = '0;
        for (int i = NUM_CP - 1; i >= 0; i--)
            if (cp_ready[i]) begin
                wr = cp_wr[i];
                rd = cp_rd[PCPI_W*i +: PCPI_W];
            end
    end

    assign any   = |cp_ready;
    assign multi = |(cp_ready & (cp_ready - NUM_CP'(1)));
endmodule

// File: rtl/picorv32_pcpi_hub.sv
// picorv32_pcpi_hub: broadcasts PCPI requests to NUM_CP coprocessors and merges their responses
module picorv32_pcpi_hub
    import picorv32_pcpi_pkg::*;
#(
    parameter int NUM_CP  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     pcpi_valid,
    input  logic [PCPI_W-1:0]        pcpi_insn,
    input  logic [PCPI_W-1:0]        pcpi_rs1,
    input  logic [PCPI_W-1:0]        pcpi_rs2,
    output logic                     pcpi_wr,
    output logic [PCPI_W-1:0]        pcpi_rd,
    output logic                     pcpi_wait,
    output logic                     pcpi_ready,
    output logic                     pcpi_timeout,
    output logic                     pcpi_conflict,
    output logic                     cp_valid,
    output logic [PCPI_W-1:0]        cp_insn,
    output logic [PCPI_W-1:0]        cp_rs1,
    output logic [PCPI_W-1:0]        cp_rs2,
    input  logic [NUM_CP-1:0]        cp_wr,
    input  logic [NUM_CP-1:0]        cp_wait,
    input  logic [NUM_CP-1:0]        cp_ready,
    input  logic [PCPI_W*NUM_CP-1:0] cp_rd
);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    hub_state_t        state;
    logic [7:0]        cnt;
    logic              sel_any, sel_multi, sel_wr;
    logic [PCPI_W-1:0] sel_rd;

    picorv32_pcpi_resp_sel #(.NUM_CP(NUM_CP)) u_sel (
        .cp_ready(cp_ready),
        .cp_wr   (cp_wr),
        .cp_rd   (cp_rd),
        .any     (sel_any),
        .multi   (sel_multi),
        .wr      (sel_wr),
        .rd      (sel_rd)
    );

    // Request is withheld in DONE/TRAP so the retiring instruction is not decoded again.
    assign cp_valid  = pcpi_valid && (state == IDLE || state == PEND || state == BUSY);
    assign cp_insn   = pcpi_insn;
    assign cp_rs1    = pcpi_rs1;
    assign cp_rs2    = pcpi_rs2;
    assign pcpi_wait = |cp_wait && (state == PEND || state == BUSY);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            cnt           <= '0;
            pcpi_wr       <= 1'b0;
            pcpi_rd       <= '0;
            pcpi_ready    <= 1'b0;
            pcpi_timeout  <= 1'b0;
            pcpi_conflict <= 1'b0;
        end else begin
            pcpi_ready   <= 1'b0;
            pcpi_timeout <= 1'b0;
            if (sel_multi) pcpi_conflict <= 1'b1;
            case (state)
                IDLE: if (pcpi_valid) begin
                    state <= PEND;
                    cnt   <= '0;
                end
                PEND, BUSY: begin
                    if (!pcpi_valid) state <= IDLE;
                    else if (sel_any) begin
                        state      <= DONE;
                        pcpi_ready <= 1'b1;
                        pcpi_wr    <= sel_wr;
                        pcpi_rd    <= sel_rd;
                    end else if (state == PEND) begin
                        if (|cp_wait) state <= BUSY;
                        else if (cnt == CNT_LAST) begin
                            state        <= TRAP;
                            pcpi_timeout <= 1'b1;
                            pcpi_wr      <= 1'b0;
                        end else cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    pcpi_wr <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/picorv32_pcpi_hub.md
# picorv32_pcpi_hub

Fan-out/fan-in stage between the core's PCPI port and up to NUM_CP coprocessors (multiplier, divider, ...). It broadcasts each PCPI request, merges `wait`/`ready`/`wr`/`rd` responses into one registered result, and signals an illegal-instruction timeout when no coprocessor claims the instruction. The core connects only to this hub; each coprocessor connects to one hub slot.

## Interface
- NUM_CP, 2: number of coprocessor slots (1..8)
- TIMEOUT, 16: cycles in PEND without any `cp_wait`/`cp_ready` before trap (4..255)
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- pcpi_valid  in  1  core request; held high until `pcpi_ready` or `pcpi_timeout`
- pcpi_insn, pcpi_rs1, pcpi_rs2  in  32 each  request payload, stable while `pcpi_valid`
- pcpi_wr  out  1  result write enable, valid with `pcpi_ready`
- pcpi_rd  out  32  result data, valid with `pcpi_ready`
- pcpi_wait  out  1  some coprocessor claims the instruction
- pcpi_ready  out  1  one-cycle completion pulse
- pcpi_timeout  out  1  one-cycle pulse: no coprocessor claimed the instruction
- pcpi_conflict  out  1  sticky: two or more `cp_ready` in the same cycle
- cp_valid  out  1  broadcast request
- cp_insn, cp_rs1, cp_rs2  out  32 each  broadcast payload (direct copies of core inputs)
- cp_wr, cp_wait, cp_ready  in  NUM_CP each  per-slot responses, bit i = slot i
- cp_rd  in  32*NUM_CP  slot i result at [32*i+31:32*i]

## Operation
- States: IDLE, PEND, BUSY, DONE, TRAP. Reset -> IDLE, counter 0; all outputs 0; `pcpi_rd` 0; `pcpi_conflict` 0.
- `cp_valid = pcpi_valid && state in {IDLE, PEND, BUSY}`. Deasserted in DONE/TRAP so coprocessors do not re-decode the retiring instruction.
- `pcpi_wait = |cp_wait && state in {PEND, BUSY}` (combinational).
- IDLE: `pcpi_valid` -> PEND, counter := 0.
- PEND: any `cp_ready` -> capture, DONE. Else any `cp_wait` -> BUSY. Else counter == TIMEOUT-1 -> TRAP. Else counter++.
- BUSY: no timeout. Any `cp_ready` -> capture, DONE.
- Capture: lowest-index i with `cp_ready[i]`; `pcpi_wr` := `cp_wr[i]`, `pcpi_rd` := slot i `rd`. If popcount(`cp_ready`) > 1, set `pcpi_conflict`.
- DONE: `pcpi_ready` = 1 for exactly one cycle -> IDLE.
- TRAP: `pcpi_timeout` = 1 for one cycle, `pcpi_wr` = 0 -> IDLE.
- `pcpi_valid` low in PEND/BUSY (abort) -> IDLE, no ready/timeout. A `cp_ready` in that same cycle is discarded.
- `pcpi_ready` clears `pcpi_wr`; `pcpi_rd` holds its last captured value.
- Any `cp_ready` seen in IDLE/DONE/TRAP is ignored. It does set `pcpi_conflict` if multi-hot.
- `resetn` low in any state -> IDLE next edge, pulses suppressed.

## Timing
- Request path to coprocessors: 0 cycles (combinational).
- `cp_ready` at cycle t -> `pcpi_ready` at t+1. Hub adds exactly one cycle to every coprocessor latency.
- Unclaimed instruction: valid rises at t0 -> PEND at t0+1 -> `pcpi_timeout` at t0+TIMEOUT+1.
- Back-to-back: valid still high in the IDLE cycle after DONE starts a new PEND. The core's new payload must be present by then.
- Critical path: priority encode of `cp_ready` into the `rd` mux (NUM_CP ≤ 8).

## Structure
- Shared package `picorv32_pcpi_pkg`: state enum, `PCPI_W = 32`, MUL/DIV opcode constants (`7'b0110011`, funct7 `7'b0000001`) reused by coprocessors and bench.
- One sub-module: `picorv32_pcpi_resp_sel` (combinational priority encoder + `rd`/`wr` mux + multi-hot detect). Hub FSM and counter stay in the top.

## Test plan
- DIVU via real divider in slot 1, rs1=100, rs2=7: `pcpi_wait` by t0+2. `pcpi_ready` one cycle after divider ready. `pcpi_wr`=1, `pcpi_rd`=14.
- REM, rs1=-100 (0xFFFFFF9C), rs2=7: `pcpi_rd`=0xFFFFFFFE. `cp_valid` low during DONE, and the divider does not restart.
- Unknown insn 0x0000000B, no claims, TIMEOUT=16: `pcpi_timeout` at exactly t0+17, single cycle. No `pcpi_ready`.
- Stub slots 0 and 1 assert `cp_ready` in the same cycle with rd 0xAAAA0000/0x5555FFFF: `pcpi_rd`=0xAAAA0000. `pcpi_conflict` rises and stays until reset.
- Abort: `pcpi_valid` dropped in BUSY while stub asserts `cp_ready` that cycle: no `pcpi_ready`, state IDLE.
- `resetn` low mid-BUSY for 1 cycle: all outputs 0 next cycle. A fresh request then completes normally.
